operand_fetch: RTL and testbench
================================

# operand_fetch

Register-read stage between decode and execute. Accepts one decoded instruction per handshake and drives the Gpr read ports (rs1/rs2/rs3 group+index). Latches the returned R/F/M operand values into an output pipeline register toward EX. Keeps a per-register busy scoreboard that is set on issue and cleared by the writeback write port, and stalls on RAW and WAW hazards until the write has landed.

## Interface
Parameters:
- MW, 512, matrix register width (M group)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ID_valid  in  1  decoded instruction available
- ready  out  1  stage accepts instruction this cycle
- ID_inst, ID_pc  in  32 each  instruction word, its pc
- ID_rs1_group/ID_rs2_group/ID_rs3_group  in  2 each  source groups (`REG_GROUP_*`)
- ID_rs1_index/ID_rs2_index/ID_rs3_index  in  5 each  source indices
- ID_rd_group, ID_rd_index, ID_rd_we  in  2, 5, 1  destination and write intent
- rs1_group..rs3_index  out  2/5  Gpr read addresses; combinational copies of ID_* source fields
- gpr_R_rs{1,2,3}, gpr_F_rs{1,2,3}  in  32 each  Gpr read data
- gpr_M_rs{1,2,3}  in  MW each  Gpr read data
- valid  out  1  operand bundle valid toward EX
- EX_ready  in  1  EX accepts bundle
- inst, pc, rd_group, rd_index, rd_we  out  32, 32, 2, 5, 1  registered copies of the ID_* fields
- src{1,2,3}_R, src{1,2,3}_F  out  32 each  latched operands
- src{1,2,3}_M  out  MW each  latched operands
- wb_we, wb_rd_group, wb_rd_index  in  1, 2, 5  writeback write port, same signals that drive Gpr

## Operation
- Scoreboard: busy_R[31:0], busy_F[31:0], busy_M[31:0].
  - busy_R[0] is hard-wired 0.
  - `REG_GROUP_INVALID` is never busy.
- Hazard:
  - Raised if any source with a valid group has its busy bit set (RAW).
  - Also raised if ID_rd_we and the busy bit of the rd is set (WAW).
  - R x0 never causes a hazard.
- ready = (~valid | EX_ready) & ~hazard.
  - ready is combinational from ID fields and scoreboard state.
  - ready is independent of ID_valid.
- Accept = ID_valid & ready. On accept, at the next clock edge:
  - All outputs load from ID_* and gpr_*. Values from a group not selected come from Gpr as 0 and are latched as 0.
  - valid <= 1.
  - If ID_rd_we and rd is not R x0 and rd is not INVALID, set the rd busy bit.
- If EX_ready & valid and there is no accept: valid <= 0. Data regs hold their values.
- If valid & ~EX_ready: all outputs hold.
- Clear: wb_we clears busy[wb_rd_group][wb_rd_index] at the clock edge.
- Set and clear of the same bit in one cycle: set wins. The new producer owns the register.
- There is no bypass. A busy bit cleared at edge N is seen clear in cycle N+1, when the Gpr already holds the new value.
- Instructions with no sources and no rd (fence, branch-free system ops) pass with no scoreboard effect.

## Timing
- Reset values: valid=0, all busy=0, inst=0, pc=0, rd_*=0, all src_*=0.
- ready during reset = 1, because valid=0 and no busy bits are set.
- Reset asserted mid-operation clears the in-flight bundle and the scoreboard immediately, with no clock needed.
- Latency: accept at edge N gives valid=1 in cycle N+1.
- Throughput: 1 per cycle when there are no hazards and EX_ready=1.
- Hazard stall: a source cleared by wb_we at edge N gives ready=1 no earlier than cycle N+1.
- Back-to-back dependent pair: the second instruction stalls until the first one's WB write, then issues the following cycle.
- The Gpr read-address outputs follow ID_* every cycle, including while stalled.

## Test plan
- Reset: assert rst asynchronously mid-cycle with valid=1 and busy_R[5]=1 -> valid=0, busy_R[5]=0 and ready=1 immediately.
- Simple issue: ID addi x5,x1,3 with gpr_R_rs1=0x10 and EX_ready=1 -> next cycle valid=1, src1_R=0x10, rd_index=5 and busy_R[5]=1.
- RAW stall: next instruction add x6,x5,x2 -> ready=0 until wb_we with R/5. At that edge busy_R[5]=0; the following cycle ready=1 and src1_R latches the written value, e.g. 0xAB.
- x0 and INVALID: issue with rd=x0 (rd_we=1), then an instruction reading x0 -> no stall, busy_R stays 0. An instruction with rs3_group=INVALID -> no stall.
- Backpressure: EX_ready=0 for 3 cycles with valid=1 -> inst, src*, valid unchanged and ready=0; then EX_ready=1 -> next bundle accepted.
- Same-cycle set/clear: wb_we clears M[7] in the same cycle an instruction with rd=M[7] issues -> busy_M[7]=1 afterward. A later reader of M[7] stalls.

Source files
------------

// File: rtl/operand_fetch.sv
// Register-read stage between decode and execute: drives Gpr read ports,
// latches R/F/M operands toward EX and tracks per-register busy bits for RAW/WAW stalls.
module operand_fetch #(
    parameter int MW = 512
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ID_valid,
    output logic          ready,
    input  logic [31:0]   ID_inst,
    input  logic [31:0]   ID_pc,
    input  logic [1:0]    ID_rs1_group,
    input  logic [1:0]    ID_rs2_group,
    input  logic [1:0]    ID_rs3_group,
    input  logic [4:0]    ID_rs1_index,
    input  logic [4:0]    ID_rs2_index,
    input  logic [4:0]    ID_rs3_index,
    input  logic [1:0]    ID_rd_group,
    input  logic [4:0]    ID_rd_index,
    input  logic          ID_rd_we,
    output logic [1:0]    rs1_group,
    output logic [1:0]    rs2_group,
    output logic [1:0]    rs3_group,
    output logic [4:0]    rs1_index,
    output logic [4:0]    rs2_index,
    output logic [4:0]    rs3_index,
    input  logic [31:0]   gpr_R_rs1,
    input  logic [31:0]   gpr_R_rs2,
    input  logic [31:0]   gpr_R_rs3,
    input  logic [31:0]   gpr_F_rs1,
    input  logic [31:0]   gpr_F_rs2,
    input  logic [31:0]   gpr_F_rs3,
    input  logic [MW-1:0] gpr_M_rs1,
    input  logic [MW-1:0] gpr_M_rs2,
    input  logic [MW-1:0] gpr_M_rs3,
    output logic          valid,
    input  logic          EX_ready,
    output logic [31:0]   inst,
    output logic [31:0]   pc,
    output logic [1:0]    rd_group,
    output logic [4:0]    rd_index,
    output logic          rd_we,
    output logic [31:0]   src1_R,
    output logic [31:0]   src2_R,
    output logic [31:0]   src3_R,
    output logic [31:0]   src1_F,
    output logic [31:0]   src2_F,
    output logic [31:0]   src3_F,
    output logic [MW-1:0] src1_M,
    output logic [MW-1:0] src2_M,
    output logic [MW-1:0] src3_M,
    input  logic          wb_we,
    input  logic [1:0]    wb_rd_group,
    input  logic [4:0]    wb_rd_index
);

    localparam logic [1:0] REG_GROUP_R       = 2'd0;
    localparam logic [1:0] REG_GROUP_F       = 2'd1;
    localparam logic [1:0] REG_GROUP_M       = 2'd2;
    localparam logic [1:0] REG_GROUP_INVALID = 2'd3;

    logic [31:0] busy_r, busy_f, busy_m;
    logic [31:0] busy_r_nxt, busy_f_nxt, busy_m_nxt;
    logic        hazard;
    logic        accept;

    function automatic logic is_busy(input logic [31:0] br, input logic [31:0] bf,
                                     input logic [31:0] bm, input logic [1:0] g,
                                     input logic [4:0] i);
        case (g)
            REG_GROUP_R: return (i != 5'd0) && br[i];
            REG_GROUP_F: return bf[i];
            REG_GROUP_M: return bm[i];
            default:     return 1'b0;
        endcase
    endfunction

    assign rs1_group = ID_rs1_group;
    assign rs2_group = ID_rs2_group;
    assign rs3_group = ID_rs3_group;
    assign rs1_index = ID_rs1_index;
    assign rs2_index = ID_rs2_index;
    assign rs3_index = ID_rs3_index;

    // No bypass: a source is only readable once its busy bit has actually cleared.
    assign hazard = is_busy(busy_r, busy_f, busy_m, ID_rs1_group, ID_rs1_index)
                  | is_busy(busy_r, busy_f, busy_m, ID_rs2_group, ID_rs2_index)
                  | is_busy(busy_r, busy_f, busy_m, ID_rs3_group, ID_rs3_index)
                  | (ID_rd_we & is_busy(busy_r, busy_f, busy_m, ID_rd_group, ID_rd_index));

    assign ready  = (~valid | EX_ready) & ~hazard;
    assign accept = ID_valid & ready;

    // NOTE: every next-state value gets a default first so no latch is inferred.
    always_comb begin
        busy_r_nxt = busy_r;
        busy_f_nxt = busy_f;
        busy_m_nxt = busy_m;
        if (wb_we) begin
            case (wb_rd_group)
                REG_GROUP_R: busy_r_nxt[wb_rd_index] = 1'b0;
                REG_GROUP_F: busy_f_nxt[wb_rd_index] = 1'b0;
                REG_GROUP_M: busy_m_nxt[wb_rd_index] = 1'b0;
                default: ;
            endcase
        end
        // Set is applied after clear so a new producer owns the register.
        if (accept && ID_rd_we) begin
            case (ID_rd_group)
                REG_GROUP_R: busy_r_nxt[ID_rd_index] = 1'b1;
                REG_GROUP_F: busy_f_nxt[ID_rd_index] = 1'b1;
                REG_GROUP_M: busy_m_nxt[ID_rd_index] = 1'b1;
                default: ;
            endcase
        end
        busy_r_nxt[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= '0;
            busy_f <= '0;
            busy_m <= '0;
        end else begin
            busy_r <= busy_r_nxt;
            busy_f <= busy_f_nxt;
            busy_m <= busy_m_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            inst     <= '0;
            pc       <= '0;
            rd_group <= '0;
            rd_index <= '0;
            rd_we    <= 1'b0;
            src1_R   <= '0;
            src2_R   <= '0;
            src3_R   <= '0;
            src1_F   <= '0;
            src2_F   <= '0;
            src3_F   <= '0;
            src1_M   <= '0;
            src2_M   <= '0;
            src3_M   <= '0;
        end else if (accept) begin
            valid    <= 1'b1;
            inst     <= ID_inst;
            pc       <= ID_pc;
            rd_group <= ID_rd_group;
            rd_index <= ID_rd_index;
            rd_we    <= ID_rd_we;
            src1_R   <= gpr_R_rs1;
            src2_R   <= gpr_R_rs2;
            src3_R   <= gpr_R_rs3;
            src1_F   <= gpr_F_rs1;
            src2_F   <= gpr_F_rs2;
            src3_F   <= gpr_F_rs3;
            src1_M   <= gpr_M_rs1;
            src2_M   <= gpr_M_rs2;
            src3_M   <= gpr_M_rs3;
        end else if (valid && EX_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch: issue, RAW/WAW stalls, x0/INVALID,
// backpressure, same-cycle set/clear and asynchronous reset.
module tb_operand_fetch;

    localparam int MW = 512;
    localparam logic [1:0] G_R   = 2'd0;
    localparam logic [1:0] G_F   = 2'd1;
    localparam logic [1:0] G_M   = 2'd2;
    localparam logic [1:0] G_INV = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ID_valid, ready;
    logic [31:0]   ID_inst, ID_pc;
    logic [1:0]    ID_rs1_group, ID_rs2_group, ID_rs3_group;
    logic [4:0]    ID_rs1_index, ID_rs2_index, ID_rs3_index;
    logic [1:0]    ID_rd_group;
    logic [4:0]    ID_rd_index;
    logic          ID_rd_we;
    logic [1:0]    rs1_group, rs2_group, rs3_group;
    logic [4:0]    rs1_index, rs2_index, rs3_index;
    logic [31:0]   gpr_R_rs1, gpr_R_rs2, gpr_R_rs3;
    logic [31:0]   gpr_F_rs1, gpr_F_rs2, gpr_F_rs3;
    logic [MW-1:0] gpr_M_rs1, gpr_M_rs2, gpr_M_rs3;
    logic          valid, EX_ready;
    logic [31:0]   inst, pc;
    logic [1:0]    rd_group;
    logic [4:0]    rd_index;
    logic          rd_we;
    logic [31:0]   src1_R, src2_R, src3_R, src1_F, src2_F, src3_F;
    logic [MW-1:0] src1_M, src2_M, src3_M;
    logic          wb_we;
    logic [1:0]    wb_rd_group;
    logic [4:0]    wb_rd_index;

    int checks = 0;
    int errors = 0;

    operand_fetch #(.MW(MW)) dut (
        .clk(clk), .rst(rst), .ID_valid(ID_valid), .ready(ready),
        .ID_inst(ID_inst), .ID_pc(ID_pc),
        .ID_rs1_group(ID_rs1_group), .ID_rs2_group(ID_rs2_group), .ID_rs3_group(ID_rs3_group),
        .ID_rs1_index(ID_rs1_index), .ID_rs2_index(ID_rs2_index), .ID_rs3_index(ID_rs3_index),
        .ID_rd_group(ID_rd_group), .ID_rd_index(ID_rd_index), .ID_rd_we(ID_rd_we),
        .rs1_group(rs1_group), .rs2_group(rs2_group), .rs3_group(rs3_group),
        .rs1_index(rs1_index), .rs2_index(rs2_index), .rs3_index(rs3_index),
        .gpr_R_rs1(gpr_R_rs1), .gpr_R_rs2(gpr_R_rs2), .gpr_R_rs3(gpr_R_rs3),
        .gpr_F_rs1(gpr_F_rs1), .gpr_F_rs2(gpr_F_rs2), .gpr_F_rs3(gpr_F_rs3),
        .gpr_M_rs1(gpr_M_rs1), .gpr_M_rs2(gpr_M_rs2), .gpr_M_rs3(gpr_M_rs3),
        .valid(valid), .EX_ready(EX_ready),
        .inst(inst), .pc(pc), .rd_group(rd_group), .rd_index(rd_index), .rd_we(rd_we),
        .src1_R(src1_R), .src2_R(src2_R), .src3_R(src3_R),
        .src1_F(src1_F), .src2_F(src2_F), .src3_F(src3_F),
        .src1_M(src1_M), .src2_M(src2_M), .src3_M(src3_M),
        .wb_we(wb_we), .wb_rd_group(wb_rd_group), .wb_rd_index(wb_rd_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [MW-1:0] observed,
                         input logic [MW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] i, input logic [31:0] p,
                          input logic [1:0] g1, input logic [4:0] x1,
                          input logic [1:0] g2, input logic [4:0] x2,
                          input logic [1:0] g3, input logic [4:0] x3,
                          input logic [1:0] dg, input logic [4:0] dx, input logic we);
        ID_inst = i;  ID_pc = p;
        ID_rs1_group = g1; ID_rs1_index = x1;
        ID_rs2_group = g2; ID_rs2_index = x2;
        ID_rs3_group = g3; ID_rs3_index = x3;
        ID_rd_group = dg; ID_rd_index = dx; ID_rd_we = we;
    endtask

    logic [MW-1:0] m_val;

    initial begin
        rst = 1'b1;
        ID_valid = 1'b0;
        EX_ready = 1'b1;
        wb_we = 1'b0; wb_rd_group = G_R; wb_rd_index = 5'd0;
        set_id(32'h0, 32'h0, G_R, 0, G_R, 0, G_R, 0, G_R, 0, 1'b0);
        gpr_R_rs1 = '0; gpr_R_rs2 = '0; gpr_R_rs3 = '0;
        gpr_F_rs1 = '0; gpr_F_rs2 = '0; gpr_F_rs3 = '0;
        gpr_M_rs1 = '0; gpr_M_rs2 = '0; gpr_M_rs3 = '0;
        m_val = {16{32'hDEADBEEF}};

        #1;
        check("rst_valid", valid, 0);
        check("rst_ready", ready, 1);
        check("rst_inst", inst, 0);
        check("rst_src1_R", src1_R, 0);
        step(); step();
        rst = 1'b0;

        // addi x5,x1,3
        set_id(32'h00308293, 32'h100, G_R, 1, G_INV, 0, G_INV, 0, G_R, 5, 1'b1);
        gpr_R_rs1 = 32'h10;
        ID_valid = 1'b1;
        #1;
        check("issue_ready", ready, 1);
        check("rd_addr_rs1_index", rs1_index, 1);
        check("rd_addr_rs2_group", rs2_group, G_INV);
        step();
        check("issue_valid", valid, 1);
        check("issue_src1_R", src1_R, 32'h10);
        check("issue_rd_index", rd_index, 5);
        check("issue_rd_we", rd_we, 1);
        check("issue_pc", pc, 32'h100);
        check("issue_inst", inst, 32'h00308293);

        // add x6,x5,x2 : RAW on x5
        set_id(32'h00228333, 32'h104, G_R, 5, G_R, 2, G_INV, 0, G_R, 6, 1'b1);
        gpr_R_rs1 = 32'h55;
        gpr_R_rs2 = 32'h22;
        #1;
        check("raw_stall_ready", ready, 0);
        check("raw_stall_rs1_index", rs1_index, 5);
        step();
        check("raw_drain_valid", valid, 0);
        check("raw_still_stalled", ready, 0);
        wb_we = 1'b1; wb_rd_group = G_R; wb_rd_index = 5'd5;
        #1;
        check("raw_before_clear", ready, 0);
        step();
        wb_we = 1'b0;
        gpr_R_rs1 = 32'hAB;
        #1;
        check("raw_after_clear_ready", ready, 1);
        check("raw_after_clear_valid", valid, 0);
        step();
        check("raw_issue_valid", valid, 1);
        check("raw_issue_src1_R", src1_R, 32'hAB);
        check("raw_issue_src2_R", src2_R, 32'h22);
        check("raw_issue_inst", inst, 32'h00228333);
        check("raw_issue_rd_index", rd_index, 6);

        // Write to x0 never sets a busy bit
        set_id(32'h00000013, 32'h108, G_R, 0, G_INV, 0, G_INV, 0, G_R, 0, 1'b1);
        gpr_R_rs1 = 32'h0; gpr_R_rs2 = 32'h0;
        #1;
        check("x0_write_ready", ready, 1);
        step();
        // Reads x0 twice; rs3 INVALID with index 6 while R6 is busy
        set_id(32'h00000033, 32'h10C, G_R, 0, G_R, 0, G_INV, 6, G_R, 0, 1'b1);
        #1;
        check("x0_invalid_no_stall", ready, 1);
        step();
        check("x0_issue_pc", pc, 32'h10C);
        // WAW on R6, no sources
        set_id(32'h00000000, 32'h110, G_INV, 0, G_INV, 0, G_INV, 0, G_R, 6, 1'b1);
        #1;
        check("waw_stall", ready, 0);
        ID_valid = 1'b0;
        wb_we = 1'b1; wb_rd_group = G_R; wb_rd_index = 5'd6;
        step();
        wb_we = 1'b0;
        check("waw_cleared", ready, 1);

        // Backpressure
        ID_valid = 1'b1;
        set_id(32'h11111111, 32'h200, G_F, 3, G_INV, 0, G_INV, 0, G_R, 7, 1'b1);
        gpr_F_rs1 = 32'hF3;
        step();
        check("bp_first_src1_F", src1_F, 32'hF3);
        EX_ready = 1'b0;
        set_id(32'h22222222, 32'h204, G_F, 4, G_INV, 0, G_INV, 0, G_R, 8, 1'b1);
        gpr_F_rs1 = 32'hF4;
        #1;
        check("bp_ready_low", ready, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_hold_valid", valid, 1);
            check("bp_hold_inst", inst, 32'h11111111);
            check("bp_hold_src1_F", src1_F, 32'hF3);
            check("bp_hold_ready", ready, 0);
        end
        EX_ready = 1'b1;
        #1;
        check("bp_release_ready", ready, 1);
        step();
        check("bp_next_inst", inst, 32'h22222222);
        check("bp_next_src1_F", src1_F, 32'hF4);
        check("bp_next_valid", valid, 1);

        // Same-cycle clear and set of M7: set wins
        set_id(32'h33333333, 32'h300, G_M, 1, G_INV, 0, G_INV, 0, G_M, 7, 1'b1);
        gpr_F_rs1 = 32'h0;
        gpr_M_rs1 = m_val;
        wb_we = 1'b1; wb_rd_group = G_M; wb_rd_index = 5'd7;
        #1;
        check("m7_issue_ready", ready, 1);
        step();
        wb_we = 1'b0;
        check("m7_src1_M", src1_M, m_val);
        check("m7_rd_group", rd_group, G_M);
        set_id(32'h44444444, 32'h304, G_M, 7, G_INV, 0, G_INV, 0, G_INV, 0, 1'b0);
        #1;
        check("m7_reader_stall", ready, 0);
        set_id(32'h44444444, 32'h304, G_F, 7, G_INV, 0, G_INV, 0, G_INV, 0, 1'b0);
        #1;
        check("f7_reader_no_stall", ready, 1);

        // Asynchronous reset mid-cycle with a bundle in flight and R5 busy
        set_id(32'h55555555, 32'h400, G_R, 1, G_INV, 0, G_INV, 0, G_R, 5, 1'b1);
        step();
        set_id(32'h66666666, 32'h404, G_R, 5, G_INV, 0, G_INV, 0, G_INV, 0, 1'b0);
        EX_ready = 1'b0;
        #1;
        check("pre_rst_valid", valid, 1);
        check("pre_rst_ready", ready, 0);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_valid", valid, 0);
        check("async_rst_ready", ready, 1);
        check("async_rst_inst", inst, 0);
        check("async_rst_src1_M", src1_M, 0);
        ID_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
